// File: rtl/ahb_nn_master.sv
// AHB-lite single-beat master front-end for one NN node.
// Commands from the NN core are queued in a small FIFO. Each command becomes
// one NONSEQ 32-bit SINGLE transfer on the fabric, and its completion status
// comes back as a one-cycle response pulse, strictly in command order.
//
// Handshake (command port): a command transfers on every rising HCLK edge
// where cmd_valid && cmd_ready. cmd_ready depends only on the FIFO count, so
// it never depends combinationally on cmd_valid. The response port has no
// back-pressure: rsp_valid is a single-cycle pulse, and rsp_rdata/rsp_err are
// meaningful only while rsp_valid is high.
module ahb_nn_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mHBUSREQ,
  input  logic        mHGRANT,
  input  logic        mHREADYin,
  input  logic [1:0]  mHRESP,
  input  logic [31:0] mHRDATA,
  output logic [31:0] mHADDR,
  output logic [1:0]  mHTRANS,
  output logic        mHWRITE,
  output logic [31:0] mHWDATA,
  output logic [2:0]  mHSIZE,
  output logic [2:0]  mHBURST,
  output logic [3:0]  mHPROT,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Command FIFO storage and bookkeeping.
  logic [31:0]   fifo_addr  [FIFO_DEPTH];
  logic [31:0]   fifo_wdata [FIFO_DEPTH];
  logic          fifo_write [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  logic [31:0]   head_addr;
  logic [31:0]   head_wdata;
  logic          head_write;

  // Data-phase supervision.
  logic [TW-1:0] tcnt;
  logic          resp_is_err;
  logic          timeout_hit;
  logic          done;
  logic          xfer_err;

  // Bus values held between transfers.
  logic [31:0]   haddr_q;
  logic          hwrite_q;
  logic [31:0]   hwdata_q;

  assign cmd_ready  = (count != CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = done;

  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  assign head_write = fifo_write[rd_ptr];

  assign mHSIZE     = 3'b010;
  assign mHBURST    = 3'b000;
  assign mHPROT     = 4'b0011;
  assign dbg_state  = state;

  // FIFO payload storage; no reset needed, the count gates every use.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
      fifo_write[wr_ptr] <= cmd_write;
    end
  end

  // FIFO pointers and occupancy; a refused push never touches them.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer completion decode in the data phase: ready, error response
  // (either cycle of the two-cycle ERROR) or wait-state timeout.
  always_comb begin
    resp_is_err = (mHRESP == HRESP_ERROR);
    timeout_hit = !mHREADYin && (tcnt == TW'(TIMEOUT - 1));
    done        = 1'b0;
    xfer_err    = 1'b0;
    if (state == DATA) begin
      done     = mHREADYin || resp_is_err || timeout_hit;
      xfer_err = resp_is_err || timeout_hit;
    end
  end

  // Wait-state counter; cleared in the address phase so it starts at 0 in DATA.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tcnt <= '0;
    end else if (state == ADDR) begin
      tcnt <= '0;
    end else if ((state == DATA) && !mHREADYin && !done) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((count != '0) || push) state_nxt = REQ;
      end
      REQ: begin
        // Grant without ready, or a grant that drops, keeps us requesting.
        if (mHGRANT && mHREADYin) state_nxt = ADDR;
      end
      ADDR: begin
        state_nxt = DATA;
      end
      DATA: begin
        if (done) begin
          if (timeout_hit) begin
            state_nxt = IDLE;
          end else if ((count > CW'(1)) || push) begin
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: address phase driven from the FIFO head, held afterwards.
  always_comb begin
    mHBUSREQ = 1'b0;
    mHTRANS  = HTRANS_IDLE;
    mHADDR   = haddr_q;
    mHWRITE  = hwrite_q;
    mHWDATA  = hwdata_q;
    case (state)
      REQ: begin
        mHBUSREQ = 1'b1;
      end
      ADDR: begin
        mHBUSREQ = 1'b1;
        mHTRANS  = HTRANS_NONSEQ;
        mHADDR   = head_addr & 32'hFFFF_FFFC;
        mHWRITE  = head_write;
      end
      DATA: begin
        mHWDATA  = head_wdata;
      end
      default: begin
        mHBUSREQ = 1'b0;
      end
    endcase
  end

  // Capture the bus values so they hold outside their own phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
    end else begin
      if (state == ADDR) begin
        haddr_q  <= head_addr & 32'hFFFF_FFFC;
        hwrite_q <= head_write;
      end
      if (state == DATA) begin
        hwdata_q <= head_wdata;
      end
    end
  end

  // Response register: one pulse per completed transfer, data only for OKAY reads.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err   <= xfer_err;
        rsp_rdata <= (!xfer_err && !head_write) ? mHRDATA : 32'h0;
      end
    end
  end

endmodule
